// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage data-memory access unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 reserved = word)
//   - FSM state encoding of the access unit
//   - default bus timeout (used only when DMEM_TIMEOUT_EN is defined)
//   - helper functions for alignment check and store lane formatting
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Half needs addr[0]==0; word (and reserved) needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: store_be = 4'b0001 << lo;
      SZ_HALF: store_be = 4'b0011 << lo;
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data into every lane it could land in.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: store_wdata = {4{wd[7:0]}};
      SZ_HALF: store_wdata = {2{wd[15:0]}};
      default: store_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load formatter.
//   rdata         in  32  raw little-endian word from the data bus
//   lane          in  2   byte offset of the access (addr[1:0])
//   size          in  2   access size (mem_pkg SZ_*)
//   load_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   data          out 32  lane-selected, extended load result
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted_s;

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  always_comb begin
    shifted_s = rdata >> {lane, 3'b000};
    case (size)
      SZ_BYTE: data = load_unsigned ? {24'd0, shifted_s[7:0]}
                                    : {{24{shifted_s[7]}}, shifted_s[7:0]};
      SZ_HALF: data = load_unsigned ? {16'd0, shifted_s[15:0]}
                                    : {{16{shifted_s[15]}}, shifted_s[15:0]};
      default: data = shifted_s;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit (EX/MEM -> MEM_WB).
// Issues one req/ack bus transaction per aligned load/store, stalls the front
// of the pipeline until it completes, and formats store lanes / load data.
// Optional feature: define DMEM_TIMEOUT_EN to add a BUSY timeout that raises
// bus_error after TIMEOUT_CYCLES cycles without ack.
// Ports:
//   clock, reset                         rising-edge clock, async active-high reset
//   MemRead_mem/MemWrite_mem             access request (write wins if both)
//   MemSize_mem, LoadUnsigned_mem        size and extension of the access
//   ALUresult_mem, WriteData_mem         effective address, right-aligned store data
//   ReadData                             registered formatted load result
//   mem_stall                            combinational pipeline freeze
//   misalign                             combinational flag while a misaligned access sits in MEM
//   bus_error                            registered timeout pulse (0 without DMEM_TIMEOUT_EN)
//   dmem_req/we/addr/wdata/be            registered data-memory bus request
//   dmem_rdata, dmem_ack                 bus response
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef DMEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead_mem,
  input  logic              MemWrite_mem,
  input  logic [1:0]        MemSize_mem,
  input  logic              LoadUnsigned_mem,
  input  logic [31:0]       ALUresult_mem,
  input  logic [31:0]       WriteData_mem,
  output logic [31:0]       ReadData,
  output logic              mem_stall,
  output logic              misalign,
  output logic              bus_error,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

  state_e            state_r;
  state_e            state_nx;
  logic              acc_s;
  logic              misal_s;
  logic              timeout_s;
  logic [ADDR_W-1:0] addr_s;
  logic [31:0]       load_data_s;

  assign addr_s  = ALUresult_mem[ADDR_W-1:0];
  assign acc_s   = MemRead_mem | MemWrite_mem;
  assign misal_s = is_misaligned(MemSize_mem, ALUresult_mem[1:0]);

  // Inputs are held stable by the stalled pipeline, so they are used directly.
  load_align u_load_align (
    .rdata         (dmem_rdata),
    .lane          (ALUresult_mem[1:0]),
    .size          (MemSize_mem),
    .load_unsigned (LoadUnsigned_mem),
    .data          (load_data_s)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt_r;

  // Fires on the edge that would complete the TIMEOUT_CYCLES-th ack-less BUSY cycle.
  assign timeout_s = (state_r == ST_BUSY) && !dmem_ack &&
                     ((wait_cnt_r + 16'd1) == TIMEOUT_LIMIT);

  // Count ack-less BUSY cycles; cleared whenever the FSM is outside BUSY.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= 16'd0;
    end else if (state_r != ST_BUSY) begin
      wait_cnt_r <= 16'd0;
    end else if (!dmem_ack) begin
      wait_cnt_r <= wait_cnt_r + 16'd1;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next state plus the combinational stall and misalign flags.
  always_comb begin
    state_nx  = state_r;
    mem_stall = 1'b0;
    misalign  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (acc_s && misal_s) begin
          misalign = 1'b1;
        end else if (acc_s) begin
          mem_stall = 1'b1;
          state_nx  = ST_BUSY;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_BUSY: begin
        mem_stall = 1'b1;
        if (dmem_ack || timeout_s) begin
          state_nx = ST_DONE;
        end else begin
          state_nx = ST_BUSY;
        end
      end
      // One unstalled cycle lets MEM_WB capture ReadData; never issue from here.
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus request registers, load result register and timeout pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      ReadData   <= 32'd0;
      bus_error  <= 1'b0;
    end else begin
      bus_error <= timeout_s;
      case (state_r)
        ST_IDLE: begin
          if (acc_s && !misal_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= MemWrite_mem;
            dmem_addr  <= {addr_s[ADDR_W-1:2], 2'b00};
            dmem_be    <= store_be(MemSize_mem, ALUresult_mem[1:0]);
            dmem_wdata <= store_wdata(MemSize_mem, WriteData_mem);
          end else if (acc_s) begin
            ReadData <= 32'd0;
          end else begin
            dmem_req <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) begin
              ReadData <= load_data_s;
            end else begin
              ReadData <= ReadData;
            end
          end else if (timeout_s) begin
            dmem_req <= 1'b0;
            ReadData <= 32'd0;
          end else begin
            dmem_req <= 1'b1;
          end
        end
        ST_DONE: dmem_req <= 1'b0;
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized bench for mem_access_unit with a
// behavioural reference model (byte arithmetic) for load/store formatting.
module tb_mem_access_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead_mem = 1'b0;
  logic        MemWrite_mem = 1'b0;
  logic [1:0]  MemSize_mem = 2'b00;
  logic        LoadUnsigned_mem = 1'b0;
  logic [31:0] ALUresult_mem = 32'd0;
  logic [31:0] WriteData_mem = 32'd0;
  logic [31:0] ReadData;
  logic        mem_stall;
  logic        misalign;
  logic        bus_error;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_ack = 1'b0;

  int          total = 0;
  int          passed = 0;
  logic [31:0] exp_rd = 32'd0;

`ifdef DMEM_TIMEOUT_EN
  localparam int LHU_DELAY = 3;
`else
  localparam int LHU_DELAY = 4;
`endif

  mem_access_unit #(
    .ADDR_W(32)
`ifdef DMEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clock(clock), .reset(reset),
    .MemRead_mem(MemRead_mem), .MemWrite_mem(MemWrite_mem),
    .MemSize_mem(MemSize_mem), .LoadUnsigned_mem(LoadUnsigned_mem),
    .ALUresult_mem(ALUresult_mem), .WriteData_mem(WriteData_mem),
    .ReadData(ReadData), .mem_stall(mem_stall), .misalign(misalign),
    .bus_error(bus_error), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int size_bytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    else if (sz == 2'b01) return 2;
    else return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdv, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic uns);
    int n;
    longint unsigned v;
    longint unsigned span;
    n = size_bytes(sz);
    span = 64'd1 << (8 * n);
    v = (longint'(rdv) >> (8 * (addr % 4))) % span;
    if (!uns && n < 4 && v >= (span / 2)) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
    int t;
    t = ((1 << size_bytes(sz)) - 1) << (addr % 4);
    return {28'd0, t[3:0]};
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    int n;
    n = size_bytes(sz);
    if (n == 1) return {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (n == 2) return {16'd0, wd[15:0]} * 32'h0001_0001;
    else return wd;
  endfunction

  task automatic clear_inputs();
    MemRead_mem = 1'b0; MemWrite_mem = 1'b0; MemSize_mem = 2'b00;
    LoadUnsigned_mem = 1'b0; ALUresult_mem = 32'd0; WriteData_mem = 32'd0;
  endtask

  // Called just after a negedge while the unit is IDLE; returns just after a negedge.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdv, input int ack_delay);
    logic mis;
    int   stalls;
    MemRead_mem = rd; MemWrite_mem = wr; MemSize_mem = sz; LoadUnsigned_mem = uns;
    ALUresult_mem = addr; WriteData_mem = wd;
    mis = ((addr % size_bytes(sz)) != 0);
    #1;
    check({tag, " misalign"}, misalign, mis);
    check({tag, " stall_idle"}, mem_stall, !mis);
    if (mis) begin
      @(posedge clock); #1;
      exp_rd = 32'd0;
      check({tag, " no_req"}, dmem_req, 1'b0);
      check({tag, " rd_cleared"}, ReadData, exp_rd);
      @(negedge clock);
      clear_inputs();
      #1;
      check({tag, " misalign_end"}, misalign, 1'b0);
    end else begin
      stalls = 1;
      @(posedge clock);
      for (int b = 0; b <= ack_delay; b++) begin
        @(negedge clock);
        if (mem_stall) stalls++;
        check({tag, " req_busy"}, dmem_req, 1'b1);
        check({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        check({tag, " we"}, dmem_we, wr);
        if (wr) begin
          check({tag, " be"}, dmem_be, model_be(addr, sz));
          check({tag, " wdata"}, dmem_wdata, model_wdata(wd, sz));
        end
        if (b == ack_delay) begin
          dmem_ack = 1'b1; dmem_rdata = rdv;
        end else begin
          dmem_rdata = $urandom;
        end
        @(posedge clock); #1;
        dmem_ack = 1'b0;
      end
      if (!wr) exp_rd = model_load(rdv, addr, sz, uns);
      @(negedge clock);
      check({tag, " stall_done"}, mem_stall, 1'b0);
      check({tag, " req_done"}, dmem_req, 1'b0);
      check({tag, " readdata"}, ReadData, exp_rd);
      check({tag, " bus_error"}, bus_error, 1'b0);
      check({tag, " stall_cycles"}, stalls, ack_delay + 2);
      @(posedge clock); #1;
      check({tag, " no_issue_from_done"}, dmem_req, 1'b0);
      @(negedge clock);
    end
  endtask

  // Idle cycles with a stray ack that must be ignored.
  task automatic idle_cycles(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) begin
      dmem_ack = 1'b1; dmem_rdata = $urandom;
      #1;
      check("idle stall", mem_stall, 1'b0);
      @(posedge clock); #1;
      dmem_ack = 1'b0;
      check("idle req", dmem_req, 1'b0);
      check("idle readdata", ReadData, exp_rd);
      @(negedge clock);
    end
  endtask

  initial begin
    int stalls;
    logic rd, wr;
    #3;
    check("reset req", dmem_req, 1'b0);
    check("reset we", dmem_we, 1'b0);
    check("reset be", dmem_be, 4'd0);
    check("reset addr", dmem_addr, 32'd0);
    check("reset wdata", dmem_wdata, 32'd0);
    check("reset readdata", ReadData, 32'd0);
    check("reset bus_error", bus_error, 1'b0);
    check("reset stall", mem_stall, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(1);

    run_access("lb",  1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0);
    check("lb value", ReadData, 32'hFFFF_FF80);
    run_access("sh",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 1);
    check("sh rd_unchanged", ReadData, 32'hFFFF_FF80);
    run_access("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 32'd0, 0);
    run_access("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_4000, 32'd0, 32'h1234_F00D, LHU_DELAY);
    check("lhu value", ReadData, 32'h0000_F00D);
    run_access("lbu_b2b", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_4001, 32'd0, 32'h1234_F00D, 0);
    run_access("sb_ld_both", 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'd0, 2);
    idle_cycles(2);

    for (int i = 0; i < 30; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      run_access("rand", rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 65535)), $urandom, $urandom, $urandom_range(0, 3));
      if (i % 5 == 4) idle_cycles(1);
    end

    // Reset in the middle of BUSY.
    run_access("pre_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'd0, 32'hCAFE_0001, 0);
    MemRead_mem = 1'b1; MemSize_mem = 2'b10; ALUresult_mem = 32'h0000_5000;
    @(posedge clock); @(negedge clock);
    check("busy req", dmem_req, 1'b1);
    @(posedge clock); #2;
    reset = 1'b1;
    clear_inputs();
    #1;
    exp_rd = 32'd0;
    check("rst req_async", dmem_req, 1'b0);
    check("rst readdata", ReadData, exp_rd);
    check("rst stall", mem_stall, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    check("late_ack readdata", ReadData, exp_rd);
    check("late_ack req", dmem_req, 1'b0);
    check("late_ack stall", mem_stall, 1'b0);
    @(negedge clock);

`ifdef DMEM_TIMEOUT_EN
    MemRead_mem = 1'b1; MemSize_mem = 2'b10; ALUresult_mem = 32'h0000_6000;
    #1;
    stalls = 0;
    for (int g = 0; g < 40 && mem_stall; g++) begin
      stalls++;
      @(posedge clock); @(negedge clock); #1;
    end
    check("to stall_cycles", stalls, 5);
    check("to bus_error", bus_error, 1'b1);
    check("to readdata", ReadData, 32'd0);
    check("to req", dmem_req, 1'b0);
    clear_inputs();
    @(posedge clock); #1;
    check("to bus_error_pulse", bus_error, 1'b0);
    @(negedge clock);
`else
    stalls = 0;
    check("no_timeout bus_error", bus_error, 1'b0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
